// File: rtl/serial_feeder_pkg.sv
// Shared types, default sizes and counter-width helpers for the serial bit feeder.
package serial_feeder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_t;

    localparam int unsigned FEEDER_WIDTH_DEF     = 8;
    localparam int unsigned FEEDER_FRAME_LEN_DEF = 21;

    // Bits needed for a down/up counter spanning 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_sync_counter.sv
// Serial frame position counter; pulses sync on frame bit 0.
// Built only when SERIAL_FEEDER_FRAME_SYNC_EN is defined.
`ifdef SERIAL_FEEDER_FRAME_SYNC_EN
module frame_sync_counter
    import serial_feeder_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FEEDER_FRAME_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic sync
);

    localparam int unsigned    FCW        = cnt_width(FRAME_LEN);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);

    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (advance) begin
            frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sync = advance && (frame_cnt_q == '0);

endmodule
`endif

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder with one-word holding buffer, MSB first, gapless.
// Frame sync generation is enabled by defining SERIAL_FEEDER_FRAME_SYNC_EN.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int unsigned WIDTH     = FEEDER_WIDTH_DEF,
    parameter int unsigned FRAME_LEN = FEEDER_FRAME_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    output logic             x_valid,
    output logic             sync,
    output logic             busy
);

    localparam int unsigned    BCW      = cnt_width(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    if (WIDTH < 2 || FRAME_LEN < 2) begin : g_cfg_check
        $error("serial_bit_feeder: WIDTH and FRAME_LEN must be >= 2");
    end

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic             accept;

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bcnt_d      = bcnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = in_data;
                    bcnt_d  = BIT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                bcnt_d = bcnt_q - 1'b1;
                if (bcnt_q == '0) begin
                    bcnt_d = BIT_LAST;
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                        if (accept) begin
                            hold_d      = in_data;
                            hold_full_d = 1'b1;
                        end
                    end else if (accept) begin
                        sreg_d = in_data;
                    end else begin
                        // sreg cleared so x reads 0 while idle
                        state_d = IDLE;
                        sreg_d  = '0;
                        bcnt_d  = '0;
                    end
                end else if (accept) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bcnt_q      <= bcnt_d;
        end
    end

    assign x       = sreg_q[WIDTH-1];
    assign x_valid = (state_q == SHIFT);
    assign busy    = (state_q == SHIFT) || hold_full_q;

`ifdef SERIAL_FEEDER_FRAME_SYNC_EN
    frame_sync_counter #(
        .FRAME_LEN(FRAME_LEN)
    ) u_frame_sync (
        .clk    (clk),
        .reset  (reset),
        .advance(x_valid),
        .sync   (sync)
    );
`else
    assign sync = 1'b0;
`endif

endmodule
